// File: rtl/path_scheduler_if.sv
// path_scheduler_if: schedule programming, control and FIFO handshake bundle of the route sequencer
interface path_scheduler_if #(
    parameter int ENTRIES = 8
);
    localparam int AW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
    logic inStart;
    logic inStop;
    logic inLoop;
    logic inCfgWrite;
    logic [AW-1:0] inCfgAddr;
    logic [16:0] inCfgData;
    logic [AW-1:0] inCfgLast;
    logic inInEmpty;
    logic inOutAlmostFull;
    logic outInReadEnable;
    logic outOutWriteEnable;
    logic [2:0] outSEL1;
    logic [1:0] outSEL6;
    logic [1:0] outSEL9;
    logic outSEL11;
    logic outSEL12;
    logic [2:0] outSEL15;
    logic outSEL17;
    logic [AW-1:0] outEntry;
    logic outBusy;
    logic outDone;
    modport master (
        output inStart, inStop, inLoop, inCfgWrite, inCfgAddr, inCfgData, inCfgLast, inInEmpty, inOutAlmostFull,
        input outInReadEnable, outOutWriteEnable, outSEL1, outSEL6, outSEL9, outSEL11, outSEL12, outSEL15,
        input outSEL17, outEntry, outBusy, outDone
    );
    modport slave (
        input inStart, inStop, inLoop, inCfgWrite, inCfgAddr, inCfgData, inCfgLast, inInEmpty, inOutAlmostFull,
        output outInReadEnable, outOutWriteEnable, outSEL1, outSEL6, outSEL9, outSEL11, outSEL12, outSEL15,
        output outSEL17, outEntry, outBusy, outDone
    );
endinterface

// File: rtl/path_scheduler.sv
// path_scheduler: steps MUX/DEMUX selects through a programmed schedule, moving a fixed word burst per entry
module path_scheduler #(
    parameter int ENTRIES = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input logic inClock,
    input logic inReset,
    path_scheduler_if.slave bus
);
    localparam int AW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN} stateType;
    stateType state, nextState;
    logic [16:0] schedule [ENTRIES];
    logic [16:0] current;
    logic [AW-1:0] entry, lastEntry;
    logic [4:0] remaining;
    logic [SW-1:0] settleCount;
    logic stopPending, pop, settled;
    always_comb begin
        current = schedule[entry];
        settled = settleCount == SW'(SETTLE_CYCLES - 1);
        pop = state == RUN && !bus.inInEmpty && !bus.inOutAlmostFull && remaining != 5'd0 && !stopPending;
    end
    always_ff @(posedge inClock or negedge inReset)
        if (!inReset) state <= IDLE;
        else state <= nextState;
    // a pending stop only redirects at state boundaries, so selects never move under an in-flight word
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = bus.inStart && !bus.inStop ? LOAD : IDLE;
            LOAD: nextState = stopPending ? DRAIN : SETTLE;
            SETTLE: nextState = !settled ? SETTLE : stopPending ? DRAIN : RUN;
            RUN: nextState = stopPending || (pop && remaining == 5'd1) ? DRAIN : RUN;
            DRAIN: nextState = stopPending || (entry == lastEntry && !bus.inLoop) ? IDLE : LOAD;
            default: nextState = IDLE;
        endcase
    end
    always_comb begin
        bus.outBusy = state != IDLE;
        bus.outInReadEnable = pop;
        bus.outEntry = entry;
    end
    always_ff @(posedge inClock)
        if (state == IDLE && bus.inCfgWrite) schedule[bus.inCfgAddr] <= bus.inCfgData;
    always_ff @(posedge inClock or negedge inReset)
        if (!inReset) begin
            entry <= '0;
            lastEntry <= '0;
            remaining <= '0;
            settleCount <= '0;
            stopPending <= 1'b0;
            bus.outOutWriteEnable <= 1'b0;
            bus.outDone <= 1'b0;
            {bus.outSEL17, bus.outSEL15, bus.outSEL12, bus.outSEL11, bus.outSEL9, bus.outSEL6, bus.outSEL1} <= '0;
        end else begin
            bus.outOutWriteEnable <= pop;
            bus.outDone <= state == DRAIN && nextState == IDLE;
            stopPending <= state != IDLE && nextState != IDLE && (stopPending || bus.inStop);
            remaining <= state == LOAD ? (current[16:13] == 4'd0 ? 5'd16 : {1'b0, current[16:13]}) : remaining - 5'(pop);
            settleCount <= state == SETTLE ? settleCount + SW'(1) : '0;
            if (state == IDLE && nextState == LOAD) begin
                entry <= '0;
                lastEntry <= bus.inCfgLast;
            end
            if (state == DRAIN && nextState == LOAD) entry <= entry == lastEntry ? '0 : entry + 1'b1;
            if (state == LOAD)
                {bus.outSEL17, bus.outSEL15, bus.outSEL12, bus.outSEL11, bus.outSEL9, bus.outSEL6, bus.outSEL1} <= current[12:0];
        end
endmodule

// File: tb/tb_path_scheduler.sv
// tb_path_scheduler: directed scenarios checked every cycle against a timeline model plus hand-computed milestones
module tb_path_scheduler;
    localparam int ENTRIES = 8;
    localparam int S = 2;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    path_scheduler_if #(.ENTRIES(ENTRIES)) bus();
    path_scheduler #(.ENTRIES(ENTRIES), .SETTLE_CYCLES(S)) dut (.inClock(clk), .inReset(rstN), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: an active run is a countdown of 1+S quiet cycles, a burst of words, then one drain cycle
    logic mActive = 1'b0, mDrain = 1'b0, mStop = 1'b0, mWe = 1'b0, mDone = 1'b0, mRe = 1'b0, mIdle = 1'b0;
    int mWait = 0, mLeft = 0;
    logic [2:0] mEntry = '0, mLast = '0;
    logic [12:0] mSel = '0;
    logic [16:0] mSched [ENTRIES];

    function automatic logic expRe();
        return mActive && mWait == 0 && !mDrain && !mStop && mLeft != 0 && !bus.inInEmpty && !bus.inOutAlmostFull;
    endfunction

    initial forever begin
        @(posedge clk or negedge rstN);
        if (!rstN) begin
            mActive = 0; mDrain = 0; mStop = 0; mWe = 0; mDone = 0; mWait = 0; mLeft = 0; mEntry = 0; mSel = 0;
        end else begin
            mRe = expRe();
            mDone = 0;
            if (!mActive) begin
                if (bus.inCfgWrite) mSched[bus.inCfgAddr] = bus.inCfgData;
                if (bus.inStart && !bus.inStop) begin
                    mActive = 1; mEntry = 0; mLast = bus.inCfgLast; mWait = 1 + S;
                end
            end else begin
                mIdle = 0;
                if (mWait > 0) begin
                    if (mWait == 1 + S) begin
                        mSel = mSched[mEntry][12:0];
                        mLeft = mSched[mEntry][16:13] == 4'd0 ? 16 : int'(mSched[mEntry][16:13]);
                    end
                    if (mStop && (mWait == 1 + S || mWait == 1)) begin
                        mWait = 0; mDrain = 1;
                    end else mWait--;
                end else if (mDrain) begin
                    mDrain = 0;
                    if (mStop || (mEntry == mLast && !bus.inLoop)) begin
                        mIdle = 1; mDone = 1;
                    end else begin
                        mEntry = mEntry == mLast ? 3'd0 : mEntry + 3'd1;
                        mWait = 1 + S;
                    end
                end else begin
                    if (mRe) mLeft--;
                    if (mStop || (mRe && mLeft == 0)) mDrain = 1;
                end
                if (mIdle) begin
                    mActive = 0; mStop = 0;
                end else mStop = mStop | bus.inStop;
            end
            mWe = mRe;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    int popCnt = 0, wrCnt = 0, doneCnt = 0, firstPop = -1, doneCyc = -1;
    logic prevBusy = 1'b0;
    logic [2:0] prevEntry = '0;
    logic [2:0] entryLog [$];

    initial forever begin
        @(negedge clk);
        check("readEnable", 32'(bus.outInReadEnable), 32'(expRe()));
        check("writeEnable", 32'(bus.outOutWriteEnable), 32'(mWe));
        check("busy", 32'(bus.outBusy), 32'(mActive));
        check("done", 32'(bus.outDone), 32'(mDone));
        check("entry", 32'(bus.outEntry), 32'(mEntry));
        check("selects", 32'({bus.outSEL17, bus.outSEL15, bus.outSEL12, bus.outSEL11, bus.outSEL9, bus.outSEL6, bus.outSEL1}), 32'(mSel));
        if (bus.outInReadEnable) begin
            popCnt++;
            if (firstPop < 0) firstPop = cyc;
        end
        if (bus.outOutWriteEnable) wrCnt++;
        if (bus.outDone) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (bus.outBusy && (!prevBusy || bus.outEntry != prevEntry)) entryLog.push_back(bus.outEntry);
        prevBusy = bus.outBusy;
        prevEntry = bus.outEntry;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        popCnt = 0; wrCnt = 0; doneCnt = 0; firstPop = -1; doneCyc = -1;
        entryLog.delete();
    endtask

    task automatic cfg(input logic [2:0] a, input logic [3:0] len, input logic [12:0] sel);
        bus.inCfgWrite = 1; bus.inCfgAddr = a; bus.inCfgData = {len, sel};
        step();
        bus.inCfgWrite = 0;
    endtask

    task automatic startRun(input logic [2:0] last, input logic lp, output int t);
        bus.inCfgLast = last; bus.inLoop = lp; bus.inStart = 1;
        step();
        bus.inStart = 0;
        t = cyc;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && doneCnt == 0; i++) step();
        check("doneTimeout", doneCnt > 0 ? 1 : 0, 1);
    endtask

    task automatic waitPops(input int n, input int budget);
        for (int i = 0; i < budget && popCnt < n; i++) step();
        check("popTimeout", popCnt >= n ? 1 : 0, 1);
    endtask

    int t0;
    initial begin
        bus.inStart = 0; bus.inStop = 0; bus.inLoop = 0; bus.inCfgWrite = 0; bus.inCfgAddr = 0;
        bus.inCfgData = 0; bus.inCfgLast = 0; bus.inInEmpty = 0; bus.inOutAlmostFull = 0;
        step(); step();
        rstN = 1;
        step();
        check("rstBusy", 32'(bus.outBusy), 0);
        check("rstSel1", 32'(bus.outSEL1), 0);
        // single entry, len 3, sel1 5: milestones relative to the start edge
        cfg(0, 4'd3, 13'd5);
        clearLog();
        startRun(0, 0, t0);
        @(negedge clk);
        check("t1SelHeldInLoad", 32'(bus.outSEL1), 0);
        @(negedge clk);
        check("t1SelAfterLoad", 32'(bus.outSEL1), 5);
        waitDone(40);
        check("t1FirstPop", firstPop, t0 + 3);
        check("t1Pops", popCnt, 3);
        check("t1Writes", wrCnt, 3);
        check("t1DoneCycle", doneCyc, t0 + 7);
        check("t1DoneCount", doneCnt, 1);
        // two looping entries, stop after the first word of the seventh visit
        cfg(0, 4'd2, 13'd1);
        cfg(1, 4'd2, 13'h1002);
        clearLog();
        startRun(1, 1, t0);
        waitPops(13, 200);
        bus.inStop = 1;
        step();
        bus.inStop = 0;
        waitDone(40);
        bus.inLoop = 0;
        check("t2Pops", popCnt, 14);
        check("t2Writes", wrCnt, 14);
        check("t2DoneCount", doneCnt, 1);
        check("t2Visits", entryLog.size(), 7);
        for (int i = 0; i < 7 && i < entryLog.size(); i++) check("t2EntrySeq", 32'(entryLog[i]), i % 2);
        // len 0 means a 16-word burst
        cfg(0, 4'd0, 13'(7 << 9));
        clearLog();
        startRun(0, 0, t0);
        waitDone(80);
        check("t3Pops", popCnt, 16);
        check("t3Writes", wrCnt, 16);
        check("t3Sel15", 32'(bus.outSEL15), 7);
        // random FIFO back-pressure
        cfg(0, 4'd5, 13'(3 << 3));
        clearLog();
        startRun(0, 0, t0);
        for (int i = 0; i < 300 && doneCnt == 0; i++) begin
            bus.inInEmpty = 1'($urandom_range(0, 1));
            bus.inOutAlmostFull = 1'($urandom_range(0, 1));
            step();
        end
        bus.inInEmpty = 0; bus.inOutAlmostFull = 0;
        waitDone(40);
        check("t4Pops", popCnt, 5);
        check("t4Writes", wrCnt, 5);
        // config write and start while busy are dropped
        cfg(0, 4'd4, 13'd3);
        clearLog();
        bus.inInEmpty = 1;
        startRun(0, 0, t0);
        step(); step(); step(); step();
        cfg(0, 4'd1, 13'd6);
        bus.inStart = 1;
        step();
        bus.inStart = 0;
        bus.inInEmpty = 0;
        waitDone(60);
        check("t5Pops", popCnt, 4);
        check("t5DoneCount", doneCnt, 1);
        clearLog();
        startRun(0, 0, t0);
        waitDone(60);
        check("t5RerunPops", popCnt, 4);
        check("t5Sel1", 32'(bus.outSEL1), 3);
        // start with stop in idle does nothing
        clearLog();
        bus.inStart = 1; bus.inStop = 1;
        step();
        bus.inStart = 0; bus.inStop = 0;
        repeat (5) step();
        check("t6Busy", 32'(bus.outBusy), 0);
        check("t6Pops", popCnt, 0);
        check("t6Done", doneCnt, 0);
        // stop raised during load: no words move
        clearLog();
        startRun(0, 0, t0);
        bus.inStop = 1;
        step();
        bus.inStop = 0;
        waitDone(40);
        check("t7Pops", popCnt, 0);
        check("t7DoneCount", doneCnt, 1);
        // asynchronous reset in the middle of a burst
        cfg(0, 4'd8, 13'h105);
        clearLog();
        startRun(0, 0, t0);
        waitPops(3, 60);
        #2;
        rstN = 0;
        #1;
        check("t8RstReadEnable", 32'(bus.outInReadEnable), 0);
        check("t8RstWriteEnable", 32'(bus.outOutWriteEnable), 0);
        check("t8RstBusy", 32'(bus.outBusy), 0);
        check("t8RstDone", 32'(bus.outDone), 0);
        check("t8RstSelects", 32'({bus.outSEL17, bus.outSEL15, bus.outSEL12, bus.outSEL11, bus.outSEL9, bus.outSEL6, bus.outSEL1}), 0);
        step(); step();
        rstN = 1;
        step();
        clearLog();
        startRun(0, 0, t0);
        waitDone(60);
        check("t8Pops", popCnt, 8);
        check("t8Writes", wrCnt, 8);
        check("t8Sel12", 32'(bus.outSEL12), 1);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
